// File: rtl/serial_alu_pkg.sv
// Shared types for the digit-serial adder/subtractor: operation codes and FSM states.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // SBC feeds ~c_in so that a - b - c_in falls out of a + ~b + carry.
    function automatic logic init_carry(input op_e op, input logic c_in);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADC:  c = c_in;
            OP_SUB:  c = 1'b1;
            default: c = ~c_in;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Ripple-carry digit adder built from full_adder cells; also exposes the carry
// into the top bit so the caller can derive signed overflow.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             c_out_o,
    output logic             c_msb_in_o
);
    logic [DIGIT:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign c_out_o    = carry[DIGIT];
    assign c_msb_in_o = carry[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, WIDTH/DIGIT cycles per operation.
// state  | meaning
// S_IDLE | ready, waiting for start
// S_RUN  | shifting digits through the adder; last digit registers result and flags
module serial_addsub
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             zero,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c_out_q, c_out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_msb_in;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a_i        (a_q[DIGIT-1:0]),
        .b_i        (b_q[DIGIT-1:0]),
        .c_i        (carry_q),
        .sum_o      (dig_sum),
        .c_out_o    (dig_cout),
        .c_msb_in_o (dig_msb_in)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        c_out_d = c_out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = a;
                    b_d     = op[1] ? ~b : b;
                    carry_d = init_carry(op_e'(op), c_in);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_q >> DIGIT;
                res_d[WIDTH-1 -: DIGIT] = dig_sum;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    out_d   = res_d;
                    c_out_d = dig_cout;
                    zero_d  = (res_d == '0);
                    ovf_d   = dig_cout ^ dig_msb_in;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            c_out_q <= c_out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign done  = done_q;
    assign out   = out_q;
    assign c_out = c_out_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: bit-serial (17/1) and digit (16/4) instances checked
// against an integer-arithmetic reference model.
module tb_serial_addsub;

    localparam int W1 = 17;
    localparam int D1 = 1;
    localparam int N1 = W1 / D1;
    localparam int W2 = 16;
    localparam int D2 = 4;
    localparam int N2 = W2 / D2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          d1_start = 1'b0;
    logic [1:0]    d1_op    = '0;
    logic [W1-1:0] d1_a     = '0;
    logic [W1-1:0] d1_b     = '0;
    logic          d1_cin   = 1'b0;
    logic          d1_ready, d1_done, d1_cout, d1_zero, d1_ovf;
    logic [W1-1:0] d1_out;

    logic          d2_start = 1'b0;
    logic [1:0]    d2_op    = '0;
    logic [W2-1:0] d2_a     = '0;
    logic [W2-1:0] d2_b     = '0;
    logic          d2_cin   = 1'b0;
    logic          d2_ready, d2_done, d2_cout, d2_zero, d2_ovf;
    logic [W2-1:0] d2_out;

    serial_addsub #(.WIDTH(W1), .DIGIT(D1)) u_dut1 (
        .clk(clk), .reset(reset), .start(d1_start), .op(d1_op), .a(d1_a), .b(d1_b),
        .c_in(d1_cin), .ready(d1_ready), .done(d1_done), .out(d1_out),
        .c_out(d1_cout), .zero(d1_zero), .ovf(d1_ovf)
    );

    serial_addsub #(.WIDTH(W2), .DIGIT(D2)) u_dut2 (
        .clk(clk), .reset(reset), .start(d2_start), .op(d2_op), .a(d2_a), .b(d2_b),
        .c_in(d2_cin), .ready(d2_ready), .done(d2_done), .out(d2_out),
        .c_out(d2_cout), .zero(d2_zero), .ovf(d2_ovf)
    );

    int sel = 0;
    logic        m_ready, m_done, m_cout, m_zero, m_ovf;
    logic [63:0] m_out;
    assign m_ready = (sel == 0) ? d1_ready : d2_ready;
    assign m_done  = (sel == 0) ? d1_done  : d2_done;
    assign m_cout  = (sel == 0) ? d1_cout  : d2_cout;
    assign m_zero  = (sel == 0) ? d1_zero  : d2_zero;
    assign m_ovf   = (sel == 0) ? d1_ovf   : d2_ovf;
    assign m_out   = (sel == 0) ? 64'(d1_out) : 64'(d2_out);

    logic [63:0] prev_out   [2];
    logic [2:0]  prev_flags [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on w-bit values.
    function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic cin,
                                  output logic [63:0] r, output logic co, output logic z,
                                  output logic ov);
        logic [63:0] mask, ua, ub, ures;
        longint      sa, sb, sres, hi, lo, extra;
        mask  = (64'd1 << w) - 64'd1;
        ua    = a & mask;
        ub    = b & mask;
        sa    = longint'(ua);
        sb    = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        extra = (op == 2'b01 || op == 2'b11) ? longint'(cin) : 0;
        if (!op[1]) begin
            ures = ua + ub + 64'(extra);
            co   = (ures >> w) != 0;
            sres = sa + sb + extra;
        end else begin
            ures = ua - ub - 64'(extra);
            co   = ua >= (ub + 64'(extra));
            sres = sa - sb - extra;
        end
        r  = ures & mask;
        z  = (r == 0);
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        ov = (sres > hi) || (sres < lo);
    endfunction

    task automatic drive(input int s, input logic st, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic cin);
        if (s == 0) begin
            d1_start = st; d1_op = op; d1_a = a[W1-1:0]; d1_b = b[W1-1:0]; d1_cin = cin;
        end else begin
            d2_start = st; d2_op = op; d2_a = a[W2-1:0]; d2_b = b[W2-1:0]; d2_cin = cin;
        end
    endtask

    task automatic do_op(input int s, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic cin, input string tag, input bit poke);
        int          w, n, cyc;
        bit          got;
        logic [63:0] r;
        logic        co, z, ov;
        sel = s;
        w   = (s == 0) ? W1 : W2;
        n   = (s == 0) ? N1 : N2;
        model(w, op, a, b, cin, r, co, z, ov);
        @(negedge clk);
        check({tag, " ready_idle"}, 64'(m_ready), 64'd1);
        drive(s, 1'b1, op, a, b, cin);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        cyc = 0;
        got = 0;
        while (!got && cyc < 4 * n + 10) begin
            @(negedge clk);
            cyc++;
            if (m_done) begin
                got = 1;
            end else begin
                if (cyc == 1) check({tag, " ready_busy"}, 64'(m_ready), 64'd0);
                if (cyc == n) begin
                    check({tag, " out_hold"}, m_out, prev_out[s]);
                    check({tag, " flags_hold"}, 64'({m_cout, m_zero, m_ovf}), 64'(prev_flags[s]));
                end
                if (poke && cyc == 2)
                    drive(s, 1'b1, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
                if (poke && cyc == 3)
                    drive(s, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
            end
        end
        check({tag, " done_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(n + 1));
        check({tag, " out"}, m_out, r);
        check({tag, " c_out"}, 64'(m_cout), 64'(co));
        check({tag, " zero"}, 64'(m_zero), 64'(z));
        check({tag, " ovf"}, 64'(m_ovf), 64'(ov));
        check({tag, " ready_at_done"}, 64'(m_ready), 64'd1);
        prev_out[s]   = r;
        prev_flags[s] = {co, z, ov};
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(m_done), 64'd0);
        check({tag, " no_stray_accept"}, 64'(m_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          ndone, last, cnt;
        logic [63:0] r;
        logic        co, z, ov;
        for (int i = 0; i < 2; i++) begin
            prev_out[i]   = '0;
            prev_flags[i] = '0;
        end

        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("rst out", m_out, 64'd0);
            check("rst flags", 64'({m_cout, m_zero, m_ovf}), 64'd0);
            check("rst done", 64'(m_done), 64'd0);
            check("rst ready", 64'(m_ready), 64'd1);
        end
        @(negedge clk);
        reset = 1'b0;

        do_op(0, 2'b00, 64'h1FFFF, 64'h00001, 1'b0, "add_wrap", 0);
        do_op(0, 2'b10, 64'h00005, 64'h00007, 1'b0, "sub_borrow", 0);
        check("sub_borrow const", m_out, 64'h1FFFE);
        do_op(0, 2'b11, 64'd5, 64'd3, 1'b1, "sbc", 0);
        check("sbc const", m_out, 64'h00001);
        do_op(0, 2'b00, 64'h0FFFF, 64'h00001, 1'b0, "add_ovf", 1);
        check("add_ovf const", 64'({m_out[16:0], m_ovf}), {46'd0, 17'h10000, 1'b1});
        do_op(0, 2'b01, 64'd0, 64'd0, 1'b1, "adc_one", 0);
        do_op(1, 2'b00, 64'h1234, 64'hEDCC, 1'b0, "d4_add", 1);
        check("d4_add const", 64'({m_out[15:0], m_cout, m_zero}), 64'({16'h0000, 1'b1, 1'b1}));
        do_op(1, 2'b10, 64'h8000, 64'h0001, 1'b0, "d4_sub_ovf", 0);

        for (int i = 0; i < 24; i++)
            do_op(int'($urandom_range(0, 1)), 2'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 1'($urandom), "rand", (i % 5) == 0);

        // start held high: acceptances must be N+1 cycles apart
        sel = 0;
        model(W1, 2'b01, 64'h0ABCD, 64'h15555, 1'b1, r, co, z, ov);
        @(negedge clk);
        drive(0, 1'b1, 2'b01, 64'h0ABCD, 64'h15555, 1'b1);
        ndone = 0;
        last  = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (d1_done) begin
                ndone++;
                if (ndone == 1) check("b2b first", 64'(k), 64'(N1 + 1));
                else            check("b2b spacing", 64'(k - last), 64'(N1 + 1));
                check("b2b out", m_out, r);
                check("b2b ready", 64'(m_ready), 64'd1);
                last = k;
            end
        end
        check("b2b count", 64'(ndone), 64'd3);
        drive(0, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        cnt = 0;
        while (!d1_done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b drain", 64'(d1_done), 64'd1);
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        drive(0, 1'b1, 2'b00, 64'h01234, 64'h00FF0, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst out", m_out, 64'd0);
        check("mid_rst flags", 64'({m_cout, m_zero, m_ovf}), 64'd0);
        check("mid_rst done", 64'(m_done), 64'd0);
        check("mid_rst ready", 64'(m_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst ready", 64'(m_ready), 64'd1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d1_done) cnt++;
        end
        check("post_rst no_done", 64'(cnt), 64'd0);
        for (int i = 0; i < 2; i++) begin
            prev_out[i]   = '0;
            prev_flags[i] = '0;
        end
        do_op(0, 2'b10, 64'h10000, 64'h00001, 1'b0, "after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
